// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: sequences an external Montgomery multiplier to compute
// X^E mod M, using either a constant-time Montgomery ladder (mode 0) or
// square-and-multiply that skips zero-bit multiplies (mode 1).
module mont_exp_ctrl #(
  parameter int unsigned N_W   = 1024,
  parameter int unsigned E_W   = 128,
  parameter int unsigned LEN_W = $clog2(E_W) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode,
  input  logic [N_W-1:0]   in_x,
  input  logic [N_W-1:0]   in_m,
  input  logic [E_W-1:0]   in_e,
  input  logic [N_W-1:0]   in_r,
  input  logic [N_W-1:0]   in_r2,
  input  logic [LEN_W-1:0] in_lene,
  output logic             mul_start,
  output logic [N_W-1:0]   mul_a,
  output logic [N_W-1:0]   mul_b,
  output logic [N_W-1:0]   mul_m,
  input  logic [N_W-1:0]   mul_res,
  input  logic             mul_done,
  output logic [N_W-1:0]   result,
  output logic             done,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TOMONT, S_MUL1, S_MUL2, S_FROMMONT, S_ERR, S_DONE
  } state_t;

  state_t           r_state;
  logic [N_W-1:0]   r_m;
  logic [N_W-1:0]   r_r;
  logic [N_W-1:0]   r_a;
  logic [N_W-1:0]   r_xt;
  logic [N_W-1:0]   r_tmp;
  logic [E_W-1:0]   r_e;
  logic [LEN_W-1:0] r_lene;
  logic [LEN_W-1:0] r_cnt;
  logic             r_mode;
  logic             r_len_ok;

  logic [LEN_W-1:0] w_shamt;
  logic             w_len_ok;
  logic             w_e_i;
  logic             w_last;
  logic             w_advance;
  logic [N_W-1:0]   w_na;
  logic [N_W-1:0]   w_nxt;

  // Length legality and left-alignment shift for the incoming exponent
  always_comb begin
    w_len_ok = (in_lene != '0) && (in_lene <= LEN_W'(E_W));
    w_shamt  = LEN_W'(E_W) - in_lene;
  end

  // Post-step A/Xt values and end-of-bit detection; SHIFT is folded into the
  // cycle that sees mul_done so the next request issues back-to-back
  always_comb begin
    w_e_i     = r_e[E_W-1];
    w_last    = (r_cnt == r_lene - LEN_W'(1));
    w_advance = mul_done && ((r_state == S_MUL2) ||
                             (r_state == S_MUL1 && r_mode && !w_e_i));
    w_na      = mul_res;
    w_nxt     = r_xt;
    if (r_state == S_MUL2 && !r_mode) begin
      if (w_e_i) begin
        w_na  = r_tmp;
        w_nxt = mul_res;
      end else begin
        w_na  = mul_res;
        w_nxt = r_tmp;
      end
    end
  end

  // Control FSM with registered multiplier request and result outputs.
  // ERR is itself the done cycle of a rejected length so the next start
  // can be taken immediately afterwards.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_r       <= '0;
      r_a       <= '0;
      r_xt      <= '0;
      r_tmp     <= '0;
      r_e       <= '0;
      r_lene    <= '0;
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_len_ok  <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_m     <= '0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      error     <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            r_m      <= in_m;
            r_r      <= in_r;
            r_e      <= in_e << w_shamt;
            r_lene   <= in_lene;
            r_mode   <= mode;
            r_cnt    <= '0;
            r_len_ok <= w_len_ok;
            r_state  <= S_LOAD;
            if (w_len_ok) begin
              mul_start <= 1'b1;
              mul_a     <= in_x;
              mul_b     <= in_r2;
              mul_m     <= in_m;
            end
          end
        end
        S_LOAD: begin
          if (!r_len_ok) begin
            done    <= 1'b1;
            error   <= 1'b1;
            result  <= '0;
            r_state <= S_ERR;
          end else begin
            r_state <= S_TOMONT;
          end
        end
        S_TOMONT: begin
          if (mul_done) begin
            r_xt      <= mul_res;
            r_a       <= r_r;
            mul_start <= 1'b1;
            mul_a     <= r_r;
            mul_b     <= r_mode ? r_r : mul_res;
            r_state   <= S_MUL1;
          end
        end
        S_MUL1: begin
          if (mul_done) begin
            if (!r_mode) begin
              r_tmp     <= mul_res;
              mul_start <= 1'b1;
              mul_a     <= w_e_i ? r_xt : r_a;
              mul_b     <= w_e_i ? r_xt : r_a;
              r_state   <= S_MUL2;
            end else if (w_e_i) begin
              r_a       <= mul_res;
              mul_start <= 1'b1;
              mul_a     <= mul_res;
              mul_b     <= r_xt;
              r_state   <= S_MUL2;
            end
          end
        end
        S_MUL2: begin
          r_state <= S_MUL2;
        end
        S_FROMMONT: begin
          if (mul_done) begin
            result  <= mul_res;
            error   <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_ERR, S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_advance) begin
        r_a       <= w_na;
        r_xt      <= w_nxt;
        r_e       <= r_e << 1;
        r_cnt     <= r_cnt + LEN_W'(1);
        mul_start <= 1'b1;
        mul_a     <= w_na;
        if (w_last) begin
          mul_b   <= N_W'(1);
          r_state <= S_FROMMONT;
        end else begin
          mul_b   <= r_mode ? w_na : w_nxt;
          r_state <= S_MUL1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed and randomised checks of mont_exp_ctrl against a behavioural
// Montgomery multiplier with programmable latency and a plain modexp model.
module tb_mont_exp_ctrl;

  localparam int unsigned N_W   = 16;
  localparam int unsigned E_W   = 8;
  localparam int unsigned LEN_W = 4;

  logic             clk;
  logic             resetn;
  logic             start;
  logic             mode;
  logic [N_W-1:0]   in_x;
  logic [N_W-1:0]   in_m;
  logic [E_W-1:0]   in_e;
  logic [N_W-1:0]   in_r;
  logic [N_W-1:0]   in_r2;
  logic [LEN_W-1:0] in_lene;
  logic             mul_start;
  logic [N_W-1:0]   mul_a;
  logic [N_W-1:0]   mul_b;
  logic [N_W-1:0]   mul_m;
  logic [N_W-1:0]   mul_res;
  logic             mul_done;
  logic [N_W-1:0]   result;
  logic             done;
  logic             busy;
  logic             error;

  int               n_chk;
  int               n_pass;
  int               lat;
  logic             spur;
  int               m_cnt;
  logic             m_done;
  logic [N_W-1:0]   m_res;

  mont_exp_ctrl #(.N_W(N_W), .E_W(E_W), .LEN_W(LEN_W)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode),
    .in_x(in_x), .in_m(in_m), .in_e(in_e), .in_r(in_r), .in_r2(in_r2),
    .in_lene(in_lene), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_m(mul_m), .mul_res(mul_res), .mul_done(mul_done), .result(result),
    .done(done), .busy(busy), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial Montgomery product a*b*2^-16 mod m
  function automatic logic [N_W-1:0] f_mont(input logic [N_W-1:0] a,
                                            input logic [N_W-1:0] b,
                                            input logic [N_W-1:0] m);
    logic [N_W+1:0] t;
    t = '0;
    for (int i = 0; i < N_W; i++) begin
      if (a[i]) t = t + (N_W+2)'(b);
      if (t[0]) t = t + (N_W+2)'(m);
      t = t >> 1;
    end
    if (t >= (N_W+2)'(m)) t = t - (N_W+2)'(m);
    return t[N_W-1:0];
  endfunction

  // Plain left-to-right modular exponentiation over the low len bits of e
  function automatic logic [N_W-1:0] f_modexp(input logic [N_W-1:0] x,
                                              input logic [E_W-1:0] e,
                                              input int len,
                                              input logic [N_W-1:0] m);
    logic [63:0] acc;
    acc = 64'd1 % 64'(m);
    for (int i = len - 1; i >= 0; i--) begin
      acc = (acc * acc) % 64'(m);
      if (e[i]) acc = (acc * 64'(x)) % 64'(m);
    end
    return acc[N_W-1:0];
  endfunction

  // Multiplier model: mul_done exactly lat cycles after mul_start
  always @(posedge clk) begin
    if (!resetn) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_start) begin
        m_res <= f_mont(mul_a, mul_b, mul_m);
        if (lat == 1) m_done <= 1'b1;
        else          m_cnt  <= lat - 1;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_done <= 1'b1;
      end
    end
  end

  assign mul_done = m_done | spur;
  assign mul_res  = m_res;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One operation: start in cycle 0, optional extra start at cycle extra_at
  task automatic t_run(input logic md, input logic [N_W-1:0] x,
                       input logic [E_W-1:0] e, input logic [LEN_W-1:0] len,
                       input logic [N_W-1:0] m, input logic [N_W-1:0] r,
                       input logic [N_W-1:0] r2, input int extra_at,
                       output logic seen, output logic [N_W-1:0] res,
                       output logic er, output int nmul, output int cyc,
                       output logic busy_gap);
    seen = 1'b0; res = '0; er = 1'b0; nmul = 0; cyc = 0; busy_gap = 1'b0;
    @(negedge clk);
    mode = md; in_x = x; in_e = e; in_lene = len; in_m = m;
    in_r = r; in_r2 = r2; start = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_at);
      if (cyc == extra_at) in_x = 16'd5;
      if (mul_start) nmul++;
      if (!busy) busy_gap = 1'b1;
      if (done) begin
        seen = 1'b1;
        res  = result;
        er   = error;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic t_case(input string tag, input logic md,
                        input logic [N_W-1:0] x, input logic [E_W-1:0] e,
                        input logic [LEN_W-1:0] len, input logic [N_W-1:0] m,
                        input logic [N_W-1:0] r, input logic [N_W-1:0] r2,
                        input int extra_at, input logic [N_W-1:0] exp_res,
                        input logic exp_err, input int exp_nmul,
                        input int exp_cyc);
    logic           seen;
    logic [N_W-1:0] res;
    logic           er;
    int             nmul;
    int             cyc;
    logic           gap;
    t_run(md, x, e, len, m, r, r2, extra_at, seen, res, er, nmul, cyc, gap);
    check({tag, ".done"},   64'(seen), 64'(1));
    check({tag, ".result"}, 64'(res),  64'(exp_res));
    check({tag, ".error"},  64'(er),   64'(exp_err));
    check({tag, ".nmul"},   64'(nmul), 64'(exp_nmul));
    check({tag, ".cycle"},  64'(cyc),  64'(exp_cyc));
    check({tag, ".busy"},   64'(gap),  64'(0));
  endtask

  initial begin
    logic [N_W-1:0] rm;
    logic [N_W-1:0] rx;
    logic [N_W-1:0] rr;
    logic [N_W-1:0] rr2;
    logic [E_W-1:0] re;
    logic [LEN_W-1:0] rl;
    int             k;
    int             nms;
    logic           seen_done;

    n_chk = 0; n_pass = 0; lat = 3; spur = 1'b0;
    resetn = 1'b0; start = 1'b0; mode = 1'b0;
    in_x = '0; in_m = '0; in_e = '0; in_r = '0; in_r2 = '0; in_lene = '0;
    repeat (3) @(negedge clk);
    check("rst.ctrl",   64'({busy, done, error, mul_start}), 64'(0));
    check("rst.result", 64'(result), 64'(0));
    check("rst.ops",    64'(mul_a | mul_b | mul_m), 64'(0));
    resetn = 1'b1;

    // M=13: R mod M = 65536 mod 13 = 3, R^2 mod M = 9
    t_case("x2e3.ladder", 1'b0, 16'd2, 8'd3, 4'd2, 16'd13, 16'd3, 16'd9, -1,
           16'd8, 1'b0, 6, 25);
    t_case("x2e3.sqmul",  1'b1, 16'd2, 8'd3, 4'd2, 16'd13, 16'd3, 16'd9, -1,
           16'd8, 1'b0, 6, 25);
    t_case("x7e11.ladder", 1'b0, 16'd7, 8'b1011, 4'd4, 16'd13, 16'd3, 16'd9, -1,
           16'd2, 1'b0, 10, 41);
    t_case("x7e11.sqmul",  1'b1, 16'd7, 8'b1011, 4'd4, 16'd13, 16'd3, 16'd9, -1,
           16'd2, 1'b0, 9, 37);
    // bits above lene are junk and must be discarded
    t_case("lead0.ladder", 1'b0, 16'd7, 8'b1100_1011, 4'd6, 16'd13, 16'd3,
           16'd9, -1, 16'd2, 1'b0, 14, 57);
    t_case("len0", 1'b0, 16'd7, 8'd11, 4'd0, 16'd13, 16'd3, 16'd9, -1,
           16'd0, 1'b1, 0, 2);
    t_case("x2e3.after_err", 1'b0, 16'd2, 8'd3, 4'd2, 16'd13, 16'd3, 16'd9, -1,
           16'd8, 1'b0, 6, 25);
    t_case("len9", 1'b1, 16'd7, 8'd11, 4'd9, 16'd13, 16'd3, 16'd9, -1,
           16'd0, 1'b1, 0, 2);
    // 2^255 mod 13 = 8, 2^1 mod 13 = 2; ladder count ignores Hamming weight
    t_case("e_ff.ladder", 1'b0, 16'd2, 8'hFF, 4'd8, 16'd13, 16'd3, 16'd9, -1,
           16'd8, 1'b0, 18, 73);
    t_case("e_01.ladder", 1'b0, 16'd2, 8'h01, 4'd8, 16'd13, 16'd3, 16'd9, -1,
           16'd2, 1'b0, 18, 73);
    t_case("e_ff.sqmul",  1'b1, 16'd2, 8'hFF, 4'd8, 16'd13, 16'd3, 16'd9, -1,
           16'd8, 1'b0, 18, 73);
    t_case("e_01.sqmul",  1'b1, 16'd2, 8'h01, 4'd8, 16'd13, 16'd3, 16'd9, -1,
           16'd2, 1'b0, 11, 45);
    // second start mid-run (with a different X) must be ignored
    t_case("midstart", 1'b0, 16'd7, 8'b1011, 4'd4, 16'd13, 16'd3, 16'd9, 10,
           16'd2, 1'b0, 10, 41);
    // issued in the cycle right after the previous done
    t_case("b2b", 1'b1, 16'd2, 8'd3, 4'd2, 16'd13, 16'd3, 16'd9, -1,
           16'd8, 1'b0, 6, 25);

    // spurious mul_done while idle
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur.ctrl", 64'({busy, done, error, mul_start}), 64'(0));
    t_case("spur.after", 1'b0, 16'd7, 8'b1011, 4'd4, 16'd13, 16'd3, 16'd9, -1,
           16'd2, 1'b0, 10, 41);

    // reset during the third multiply
    @(negedge clk);
    mode = 1'b0; in_x = 16'd7; in_e = 8'b1011; in_lene = 4'd4;
    in_m = 16'd13; in_r = 16'd3; in_r2 = 16'd9; start = 1'b1;
    nms = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mul_start) nms++;
      if (nms == 3) break;
    end
    check("rst_mid.third_mul", 64'(nms), 64'(3));
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst_mid.ctrl",   64'({busy, done, error, mul_start}), 64'(0));
    check("rst_mid.result", 64'(result), 64'(0));
    check("rst_mid.ops",    64'(mul_a | mul_b | mul_m), 64'(0));
    resetn = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    check("rst_mid.nodone", 64'(seen_done), 64'(0));

    // randomised operands against the plain modexp model
    for (int li = 0; li < 2; li++) begin
      lat = (li == 0) ? 1 : 5;
      for (int md = 0; md < 2; md++) begin
        for (int it = 0; it < 3; it++) begin
          rm  = 16'($urandom_range(3, 65535)) | 16'd1;
          rx  = 16'($urandom % 32'(rm));
          re  = 8'($urandom);
          rl  = 4'($urandom_range(1, 8));
          rr  = 16'(32'h1_0000 % 32'(rm));
          rr2 = 16'((32'(rr) * 32'(rr)) % 32'(rm));
          if (md == 0) begin
            k = 2 + 2 * int'(rl);
          end else begin
            k = 2 + int'(rl);
            for (int b = 0; b < int'(rl); b++) if (re[b]) k++;
          end
          t_case($sformatf("rand.l%0d.m%0d.%0d", lat, md, it), md[0], rx, re,
                 rl, rm, rr, rr2, -1, f_modexp(rx, re, int'(rl), rm), 1'b0,
                 k, k * (lat + 1) + 1);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
